// File: rtl/mpf_svc_vtp_l1_miss_coalesce.sv
// mpf_svc_vtp_l1_miss_coalesce: in-order L1 miss buffer issuing one L2 lookup per same-page run.
// Define MPF_VTP_L1_MISS_COALESCE_EN to enable leader/follower coalescing; otherwise every miss is a leader.
module mpf_svc_vtp_l1_miss_coalesce #(
   parameter int DEPTH = 16,
   parameter int MAX_L2_OUTSTANDING = 8,
   parameter int OPAQUE_BITS = 8,
   parameter int VA_IDX_BITS = 36,
   parameter int PA_IDX_BITS = 28
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   reqEn,
   input  logic [VA_IDX_BITS-1:0] reqVA,
   input  logic [OPAQUE_BITS-1:0] reqOpaque,
   output logic                   notFull,
   output logic                   notEmpty,
   input  logic                   tlbInval,
   output logic                   l2ReqEn,
   output logic [VA_IDX_BITS-1:0] l2ReqVA,
   input  logic                   l2ReqRdy,
   input  logic                   l2RspEn,
   input  logic [PA_IDX_BITS-1:0] l2RspPA,
   input  logic                   l2RspBigPage,
   input  logic                   l2RspError,
   output logic                   rspValid,
   output logic [PA_IDX_BITS-1:0] rspPA,
   output logic                   rspBigPage,
   output logic                   rspError,
   output logic [OPAQUE_BITS-1:0] rspOpaque,
   input  logic                   rspWaitRequest
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = (MAX_L2_OUTSTANDING > 1) ? $clog2(MAX_L2_OUTSTANDING) : 1;
   localparam int OW = $clog2(MAX_L2_OUTSTANDING + 1);
   localparam int TW = PA_IDX_BITS + 2;

   logic [OPAQUE_BITS:0]   ent_mem [DEPTH];
   logic [VA_IDX_BITS-1:0] iss_mem [DEPTH];
   logic [TW-1:0]          res_mem [MAX_L2_OUTSTANDING];

   logic [AW-1:0] ent_wp_q, ent_wp_d, ent_rp_q, ent_rp_d, iss_wp_q, iss_wp_d, iss_rp_q, iss_rp_d;
   logic [CW-1:0] ent_cnt_q, ent_cnt_d, iss_cnt_q, iss_cnt_d;
   logic [RW-1:0] res_wp_q, res_wp_d, res_rp_q, res_rp_d;
   logic [OW-1:0] res_cnt_q, res_cnt_d, out_cnt_q, out_cnt_d;
   logic [TW-1:0] last_rsp_q, last_rsp_d, rsp_q, rsp_d, res_head;
   logic [OPAQUE_BITS-1:0] rsp_opq_q, rsp_opq_d;
   logic rsp_vld_q, rsp_vld_d;
   logic accept, leader, iss_push, iss_pop, head_lead, out_pop, res_pop;

`ifdef MPF_VTP_L1_MISS_COALESCE_EN
   logic [VA_IDX_BITS-1:0] last_va_q, last_va_d;
   logic last_va_vld_q, last_va_vld_d;
   // A shootdown forces a fresh lookup even for a repeat of the last page.
   always_comb begin
      leader = tlbInval || !(last_va_vld_q && reqVA == last_va_q);
      last_va_d = (accept && leader) ? reqVA : last_va_q;
      last_va_vld_d = (accept && leader) || (last_va_vld_q && !tlbInval);
   end
   always_ff @(posedge clk) begin
      last_va_q <= last_va_d;
      last_va_vld_q <= reset_n ? last_va_vld_d : 1'b0;
   end
`else
   logic unused_inval;
   assign unused_inval = tlbInval;
   always_comb leader = 1'b1;
`endif

   always_comb begin
      notFull = ent_cnt_q != CW'(DEPTH);
      accept = reqEn && notFull;
      iss_push = accept && leader;
      iss_pop = iss_cnt_q != '0 && l2ReqRdy && out_cnt_q != OW'(MAX_L2_OUTSTANDING);
      head_lead = ent_mem[ent_rp_q][OPAQUE_BITS];
      res_head = res_mem[res_rp_q];
      // Followers reuse the latched leader result, so only leaders wait on L2.
      out_pop = ent_cnt_q != '0 && !rspWaitRequest && (!head_lead || res_cnt_q != '0);
      res_pop = out_pop && head_lead;
      ent_wp_d = ent_wp_q + AW'(accept);
      ent_rp_d = ent_rp_q + AW'(out_pop);
      ent_cnt_d = ent_cnt_q + CW'(accept) - CW'(out_pop);
      iss_wp_d = iss_wp_q + AW'(iss_push);
      iss_rp_d = iss_rp_q + AW'(iss_pop);
      iss_cnt_d = iss_cnt_q + CW'(iss_push) - CW'(iss_pop);
      res_wp_d = !l2RspEn ? res_wp_q : (res_wp_q == RW'(MAX_L2_OUTSTANDING - 1) ? '0 : res_wp_q + 1'b1);
      res_rp_d = !res_pop ? res_rp_q : (res_rp_q == RW'(MAX_L2_OUTSTANDING - 1) ? '0 : res_rp_q + 1'b1);
      res_cnt_d = res_cnt_q + OW'(l2RspEn) - OW'(res_pop);
      out_cnt_d = out_cnt_q + OW'(iss_pop) - OW'(res_pop);
      last_rsp_d = res_pop ? res_head : last_rsp_q;
      rsp_vld_d = out_pop;
      rsp_d = out_pop ? last_rsp_d : rsp_q;
      rsp_opq_d = out_pop ? ent_mem[ent_rp_q][OPAQUE_BITS-1:0] : rsp_opq_q;
   end

   always_ff @(posedge clk) begin
      if (accept) ent_mem[ent_wp_q] <= {leader, reqOpaque};
      if (iss_push) iss_mem[iss_wp_q] <= reqVA;
      if (l2RspEn) res_mem[res_wp_q] <= {l2RspPA, l2RspBigPage, l2RspError};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ent_wp_q <= '0;
         ent_rp_q <= '0;
         ent_cnt_q <= '0;
         iss_wp_q <= '0;
         iss_rp_q <= '0;
         iss_cnt_q <= '0;
         res_wp_q <= '0;
         res_rp_q <= '0;
         res_cnt_q <= '0;
         out_cnt_q <= '0;
         rsp_vld_q <= 1'b0;
      end else begin
         ent_wp_q <= ent_wp_d;
         ent_rp_q <= ent_rp_d;
         ent_cnt_q <= ent_cnt_d;
         iss_wp_q <= iss_wp_d;
         iss_rp_q <= iss_rp_d;
         iss_cnt_q <= iss_cnt_d;
         res_wp_q <= res_wp_d;
         res_rp_q <= res_rp_d;
         res_cnt_q <= res_cnt_d;
         out_cnt_q <= out_cnt_d;
         rsp_vld_q <= rsp_vld_d;
      end
      last_rsp_q <= last_rsp_d;
      rsp_q <= rsp_d;
      rsp_opq_q <= rsp_opq_d;
   end

   assign l2ReqEn = iss_pop;
   assign l2ReqVA = iss_mem[iss_rp_q];
   assign notEmpty = ent_cnt_q != '0 || out_cnt_q != '0 || rsp_vld_q;
   assign rspValid = rsp_vld_q;
   assign {rspPA, rspBigPage, rspError} = rsp_q;
   assign rspOpaque = rsp_opq_q;
endmodule
